alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Parametrised execute-stage ALU for the pipelined RISC-V core. It decodes ALUOp/funct3/funct7 into an internal ALU control code, computes the result and registers it behind a valid/ready handshake. It adds full RV32I ALU coverage, I-type decode and an iterative multi-cycle MUL. It sits between the ID/EX pipeline register and EX/MEM, and supports hazard-unit stall (out_ready) and branch flush.

Parameters:
XLEN, 32, datapath width in bits; legal values are 32 or 64.
MUL_EN, 1, 1 enables MUL (funct7=0000001, funct3=000); 0 makes it illegal.
MUL_STEP, 1, multiplier bits retired per cycle; must divide XLEN; legal values are 1, 2 or 4.

Ports:
clk  in  1  the single clock; rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operation presented.
in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
alu_op  in  2  00=ADD (load/store), 01=SUB (branch), 10=R-type decode, 11=I-type decode.
funct3  in  3  instruction funct3.
funct7  in  7  instruction funct7 (I-type: only bit 5 used, for SRAI).
op_a  in  XLEN  rs1 operand.
op_b  in  XLEN  rs2 or immediate.
flush  in  1  kill in-flight and held results.
out_valid  out  1  result register holds a valid result.
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
result  out  XLEN  ALU result.
zero  out  1  result == 0, registered with result.
illegal  out  1  decode failed; result forced to 0.

Behaviour:
- Reset (rst_n low, async): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, mul counter=0. in_ready=0 while rst_n low.
- Decode (combinational on accept):
  - alu_op 10 maps {funct7,funct3} to AND/OR/XOR/ADD/SUB/SLL/SRL/SRA/SLT/SLTU. funct7 0100000 is legal only with 000 (SUB) or 101 (SRA).
  - alu_op 11: funct7 is ignored except for the shifts (001 needs funct7=0; 101 needs funct7 0 or 0100000). There is no SUBI: 000 is ADD.
  - Any other combination is illegal.
- Shift amount = op_b[log2(XLEN)-1:0]. SLT is signed, SLTU unsigned; both zero-extend to XLEN.
- FSM states: IDLE, MUL, HOLD.
  - in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
  - Single-cycle op accepted at edge N: result/zero/illegal/out_valid=1 registered at N; visible in cycle N+1. Throughput is 1 per cycle.
  - MUL accepted at N: IDLE->MUL, iterative shift-add for XLEN/MUL_STEP cycles. Low XLEN bits of the product are written, and out_valid rises XLEN/MUL_STEP+1 cycles after accept. The FSM then returns to IDLE.
  - If out_valid && !out_ready when a result completes: state HOLD. result, zero and illegal stay stable and in_ready=0 until out_ready, then IDLE.
  - A result that is out_valid && !out_ready is never overwritten or altered.
- Output transfer with no new accept in the same cycle: out_valid drops next cycle.
- Transfer plus accept in the same cycle: out_valid stays 1 with the new result.
- flush (highest priority after reset): next edge sets out_valid=0, aborts MUL and clears the counter, state=IDLE. Any in_valid during flush is not accepted (in_ready=0).
- Illegal op: 1-cycle latency, result=0, zero=1, illegal=1. MUL with MUL_EN=0 is handled the same way.
- Overflow: ADD/SUB/MUL wrap modulo 2^XLEN with no flags.

Decomposition:
- Package alu_pkg:
  - alu_ctl_e enum (4-bit): AND=0, OR=1, ADD=2, SUB=6, SLT=7, SLTU=8, XOR=9, SLL=10, SRL=11, SRA=12, MUL=13, ILL=15. The legacy codes 0/1/2/6/15 keep their meaning.
  - ALUOp constants, funct3/funct7 constants, and the FSM state enum.
- Submodule alu_iter_mul (params XLEN, MUL_STEP): start/abort/done interface plus product output. It owns the counter and accumulator.

Test Plan:
- Reset mid-MUL: assert rst_n=0 at cycle 3 of a MUL -> out_valid=0, result=0 immediately; in_ready=1 after release.
- R-type back-to-back, out_ready=1: ADD 5+7, SUB 5-7, SRA 0x80000000>>4, SLTU 1<0xFFFFFFFF -> out_valid 1 cycle later each. Results 12, 0xFFFFFFFE, 0xF8000000, 1 in consecutive cycles.
- I-type: alu_op=11, funct3=000, funct7=0100000, 3+4 -> result 7 (no SUBI). funct3=001, funct7=0100000 -> illegal=1, result=0, zero=1.
- MUL XLEN=32, MUL_STEP=1: 0xFFFFFFFF*3 -> result 0xFFFFFFFD, out_valid exactly 33 cycles after accept, in_ready=0 throughout. Repeat with MUL_STEP=4: 9 cycles.
- Backpressure: out_ready=0 for 4 cycles holding ADD result 12 -> result stable and in_ready=0. When out_ready=1 with the next op valid, both transfers happen in the same cycle.
- Flush: flush at cycle 10 of a MUL, with in_valid=1 in the same cycle -> no out_valid, input not accepted, state IDLE. A new ADD next cycle completes with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: control codes, decode constants,
// FSM states and the ALUOp/funct decoder.
package alu_pkg;

   typedef enum logic [3:0] {
      CTL_AND  = 4'd0,
      CTL_OR   = 4'd1,
      CTL_ADD  = 4'd2,
      CTL_SUB  = 4'd6,
      CTL_SLT  = 4'd7,
      CTL_SLTU = 4'd8,
      CTL_XOR  = 4'd9,
      CTL_SLL  = 4'd10,
      CTL_SRL  = 4'd11,
      CTL_SRA  = 4'd12,
      CTL_MUL  = 4'd13,
      CTL_ILL  = 4'd15
   } alu_ctl_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } alu_state_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   function automatic alu_ctl_e alu_decode(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic mul_en);
      alu_ctl_e ctl;
      ctl = CTL_ILL;
      case (op)
         ALUOP_ADD: ctl = CTL_ADD;
         ALUOP_SUB: ctl = CTL_SUB;
         ALUOP_RTYPE: begin
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD:  ctl = CTL_ADD;
                  F3_SLL:  ctl = CTL_SLL;
                  F3_SLT:  ctl = CTL_SLT;
                  F3_SLTU: ctl = CTL_SLTU;
                  F3_XOR:  ctl = CTL_XOR;
                  F3_SR:   ctl = CTL_SRL;
                  F3_OR:   ctl = CTL_OR;
                  default: ctl = CTL_AND;
               endcase
            end else if (f7 == F7_ALT) begin
               if (f3 == F3_ADD)
                  ctl = CTL_SUB;
               else if (f3 == F3_SR)
                  ctl = CTL_SRA;
            end else if (f7 == F7_MULDIV && f3 == F3_ADD && mul_en) begin
               ctl = CTL_MUL;
            end
         end
         default: begin
            // I-type: funct7 only qualifies the shifts; there is no SUBI
            case (f3)
               F3_ADD:  ctl = CTL_ADD;
               F3_SLT:  ctl = CTL_SLT;
               F3_SLTU: ctl = CTL_SLTU;
               F3_XOR:  ctl = CTL_XOR;
               F3_OR:   ctl = CTL_OR;
               F3_AND:  ctl = CTL_AND;
               F3_SLL:  ctl = (f7 == F7_BASE) ? CTL_SLL : CTL_ILL;
               default: ctl = (f7 == F7_BASE) ? CTL_SRL :
                              (f7 == F7_ALT)  ? CTL_SRA : CTL_ILL;
            endcase
         end
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/alu_exec_stage_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle;
// product holds the low XLEN bits and is valid in the cycle done is high.
module alu_iter_mul
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int STEPS = XLEN / MUL_STEP;
   localparam int CNT_W = $clog2(STEPS + 1);

   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_acc;
   logic [XLEN-1:0]  r_mcand;
   logic [XLEN-1:0]  r_mplier;
   logic [XLEN-1:0]  w_acc_nxt;

   always_comb begin
      w_acc_nxt = r_acc;
      for (int j = 0; j < MUL_STEP; j++) begin
         if (r_mplier[j])
            w_acc_nxt = w_acc_nxt + (r_mcand << j);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (abort)
         r_cnt <= '0;
      else if (start)
         r_cnt <= CNT_W'(STEPS);
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   // Datapath needs no reset; it is fully loaded on start
   always_ff @(posedge clk) begin
      if (start) begin
         r_acc    <= '0;
         r_mcand  <= a;
         r_mplier <= b;
      end else if (r_cnt != '0) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << MUL_STEP;
         r_mplier <= r_mplier >> MUL_STEP;
      end
   end

   // Once all multiplier bits are shifted out w_acc_nxt equals r_acc,
   // so the product stays stable after completion.
   assign done    = (r_cnt == CNT_W'(1));
   assign product = w_acc_nxt;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: decodes ALUOp/funct3/funct7, computes single-cycle ops or
// an iterative MUL, and registers the result behind a valid/ready handshake.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_EN   = 1,
   parameter int MUL_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);

   alu_ctl_e               w_ctl;
   alu_state_e             r_state;
   logic signed [XLEN-1:0] w_a_s;
   logic signed [XLEN-1:0] w_b_s;
   logic [SHW-1:0]         w_shamt;
   logic [XLEN-1:0]        w_alu_res;
   logic [XLEN-1:0]        w_mul_prod;
   logic                   w_mul_done;
   logic                   w_out_free;
   logic                   w_accept;
   logic                   w_mul_start;
   logic                   r_vld_p1;
   logic [XLEN-1:0]        r_result_p1;
   logic                   r_zero_p1;
   logic                   r_illegal_p1;

   assign w_ctl       = alu_decode(alu_op, funct3, funct7, MUL_EN != 0);
   assign w_a_s       = op_a;
   assign w_b_s       = op_b;
   assign w_shamt     = op_b[SHW-1:0];
   assign w_out_free  = !r_vld_p1 || out_ready;
   assign in_ready    = rst_n && (r_state == ST_IDLE) && !flush && w_out_free;
   assign w_accept    = in_valid && in_ready;
   assign w_mul_start = w_accept && (w_ctl == CTL_MUL);

   always_comb begin
      w_alu_res = '0;
      case (w_ctl)
         CTL_AND:  w_alu_res = op_a & op_b;
         CTL_OR:   w_alu_res = op_a | op_b;
         CTL_XOR:  w_alu_res = op_a ^ op_b;
         CTL_ADD:  w_alu_res = op_a + op_b;
         CTL_SUB:  w_alu_res = op_a - op_b;
         CTL_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
         CTL_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         CTL_SLL:  w_alu_res = op_a << w_shamt;
         CTL_SRL:  w_alu_res = op_a >> w_shamt;
         CTL_SRA:  w_alu_res = w_a_s >>> w_shamt;
         default:  w_alu_res = '0;
      endcase
   end

   alu_iter_mul #(
      .XLEN     (XLEN),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_mul_start),
      .abort   (flush),
      .a       (op_a),
      .b       (op_b),
      .done    (w_mul_done),
      .product (w_mul_prod)
   );

   // ---- Output register stage (p1) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_vld_p1     <= 1'b0;
         r_result_p1  <= '0;
         r_zero_p1    <= 1'b0;
         r_illegal_p1 <= 1'b0;
      end else if (flush) begin
         r_state  <= ST_IDLE;
         r_vld_p1 <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept && w_ctl == CTL_MUL) begin
                  r_state  <= ST_MUL;
                  r_vld_p1 <= 1'b0;
               end else if (w_accept) begin
                  r_vld_p1     <= 1'b1;
                  r_result_p1  <= w_alu_res;
                  r_zero_p1    <= (w_alu_res == '0);
                  r_illegal_p1 <= (w_ctl == CTL_ILL);
               end else if (out_ready) begin
                  r_vld_p1 <= 1'b0;
               end
            end
            ST_MUL: begin
               if (w_mul_done && w_out_free) begin
                  r_state      <= ST_IDLE;
                  r_vld_p1     <= 1'b1;
                  r_result_p1  <= w_mul_prod;
                  r_zero_p1    <= (w_mul_prod == '0);
                  r_illegal_p1 <= 1'b0;
               end else if (w_mul_done) begin
                  // Output still occupied: park the product in the multiplier
                  r_state <= ST_HOLD;
               end else if (out_ready) begin
                  r_vld_p1 <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_state      <= ST_IDLE;
                  r_vld_p1     <= 1'b1;
                  r_result_p1  <= w_mul_prod;
                  r_zero_p1    <= (w_mul_prod == '0);
                  r_illegal_p1 <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_vld_p1;
   assign result    = r_result_p1;
   assign zero      = r_zero_p1;
   assign illegal   = r_illegal_p1;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed vectors push expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_exec_stage;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          exp_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_valid4, in_ready4;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] op_a, op_b;
   logic        flush;
   logic        out_valid, out_ready, out_valid4;
   logic        out_ready4 = 1'b1;
   logic [31:0] result, result4;
   logic        zero, illegal, zero4, illegal4;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_exec_stage #(.XLEN(32), .MUL_EN(1), .MUL_STEP(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal));

   alu_exec_stage #(.XLEN(32), .MUL_EN(1), .MUL_STEP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
      .flush(flush), .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .zero(zero4), .illegal(illegal4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Present one op, wait (bounded) for acceptance, optionally queue the expectation.
   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic eill, input int lat, input bit push, output int waits);
      bit acc;
      exp_t e;
      alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
      in_valid = 1'b1;
      waits = 0;
      acc = 1'b0;
      while (!acc && waits < 100) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            if (push) begin
               e.res = er; e.zero = (er == 32'd0); e.ill = eill;
               e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
               q.push_back(e);
            end
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: every transfer must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", result, 32'hxxxxxxxx);
            end else begin
               e = q.pop_front();
               chk("result", result, e.res);
               chk("zero", {31'd0, zero}, {31'd0, e.zero});
               chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
               if (e.exp_cyc >= 0) chk("latency_cycle", cyc, e.exp_cyc);
            end
         end
      end
   end

   initial begin
      int w, bad, k;
      bit seen;
      rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; flush = 1'b0;
      alu_op = 2'b00; funct3 = 3'd0; funct7 = 7'd0; op_a = 32'd0; op_b = 32'd0;

      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // R-type back-to-back, then assorted single-cycle ops
      issue(2'b10, 3'b000, 7'h00, 32'd5, 32'd7, 32'd12, 1'b0, 1, 1, w);
      issue(2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1, 1, w);
      issue(2'b10, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1, 1, w);
      issue(2'b10, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1, 1, w);
      issue(2'b10, 3'b111, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, 1, w);
      issue(2'b10, 3'b110, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1, 1, w);
      issue(2'b10, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1, 1, w);
      issue(2'b10, 3'b001, 7'h00, 32'd1, 32'd31, 32'h80000000, 1'b0, 1, 1, w);
      issue(2'b10, 3'b001, 7'h00, 32'd1, 32'd33, 32'd2, 1'b0, 1, 1, w);
      issue(2'b10, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1, 1, w);
      issue(2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1, 1, w);
      issue(2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1, 1, w);
      issue(2'b00, 3'b111, 7'h20, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1, 1, w);
      issue(2'b01, 3'b000, 7'h00, 32'd7, 32'd7, 32'd0, 1'b0, 1, 1, w);
      issue(2'b10, 3'b001, 7'h20, 32'd3, 32'd4, 32'd0, 1'b1, 1, 1, w);
      issue(2'b10, 3'b001, 7'h01, 32'd3, 32'd4, 32'd0, 1'b1, 1, 1, w);
      // I-type
      issue(2'b11, 3'b000, 7'h20, 32'd3, 32'd4, 32'd7, 1'b0, 1, 1, w);
      issue(2'b11, 3'b001, 7'h20, 32'd3, 32'd4, 32'd0, 1'b1, 1, 1, w);
      issue(2'b11, 3'b101, 7'h20, 32'hFFFFFF00, 32'd8, 32'hFFFFFFFF, 1'b0, 1, 1, w);
      issue(2'b11, 3'b101, 7'h01, 32'hFFFFFF00, 32'd8, 32'd0, 1'b1, 1, 1, w);

      // MUL, MUL_STEP=1: 33-cycle latency, in_ready low throughout
      issue(2'b10, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0, 33, 1, w);
      bad = 0; seen = 1'b0;
      for (k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else if (in_ready) bad++;
      end
      chk("mul_in_ready_low", bad, 32'd0);
      chk("mul_completed", {31'd0, seen}, 32'd1);
      @(posedge clk); #1;

      // MUL, MUL_STEP=4: 9-cycle latency
      alu_op = 2'b10; funct3 = 3'b000; funct7 = 7'h01; op_a = 32'hFFFFFFFF; op_b = 32'd3;
      in_valid4 = 1'b1;
      @(negedge clk);
      chk("mul4_in_ready", {31'd0, in_ready4}, 32'd1);
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      k = 0; seen = 1'b0;
      while (!seen && k < 30) begin
         @(negedge clk);
         k++;
         if (out_valid4) seen = 1'b1;
      end
      chk("mul4_latency", k, 32'd9);
      chk("mul4_result", result4, 32'hFFFFFFFD);
      @(posedge clk); #1;

      // Backpressure: hold ADD result, then transfer and accept in the same cycle
      out_ready = 1'b0;
      issue(2'b10, 3'b000, 7'h00, 32'd5, 32'd7, 32'd12, 1'b0, -1, 1, w);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (!(out_valid === 1'b1 && result === 32'd12 && zero === 1'b0 && in_ready === 1'b0))
            bad++;
      end
      chk("hold_stable", bad, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      issue(2'b10, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 1'b0, 1, 1, w);
      chk("hold_release_same_cycle", w, 32'd0);

      // Flush at cycle 10 of a MUL with a competing in_valid
      issue(2'b10, 3'b000, 7'h01, 32'd6, 32'd7, 32'd42, 1'b0, 33, 0, w);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      alu_op = 2'b00; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      issue(2'b00, 3'b000, 7'h00, 32'd2, 32'd2, 32'd4, 1'b0, 1, 1, w);
      repeat (40) @(posedge clk);
      #1;

      // Async reset during a MUL
      issue(2'b10, 3'b000, 7'h01, 32'd6, 32'd7, 32'd42, 1'b0, 33, 0, w);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_result", result, 32'd0);
      chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_release_ready", {31'd0, in_ready}, 32'd1);
      repeat (40) @(posedge clk);
      #1;

      chk("scoreboard_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
